// File: rtl/bsram_arbiter.sv
// bsram_arbiter: two-requester round-robin arbiter in front of a same-cycle-read SRAM, with zero-fill after reset
// Ports:
//   clock, reset (sync, active-low)
//   reqN_valid/write/addr/wdata -> reqN_ready  : requester N access handshake
//   respN_valid/respN_rdata                    : one-cycle completion pulse, read result
//   mem_*                                      : SRAM read/write port (mem_readData same cycle)
//   init_done                                  : memory cleared and accessible
//   report                                     : simulation tracing hook, no effect on hardware
module bsram_arbiter #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter bit INIT_CLEAR = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic                  mem_readEnable,
    output logic [ADDR_WIDTH-1:0] mem_readAddress,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    output logic                  init_done,
    input  logic                  report
);
    typedef enum logic {INIT, SERVE} state_t;
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ptr, r_init_done;
    logic [1:0]            r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
    logic                  w_serve, w_clear, w_g0, w_g1, w_any, w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_unused;

    assign w_unused = report ^ (CORE < 0);

    always_comb begin
        w_serve = reset && r_state == SERVE;
        w_clear = reset && r_state == INIT;
        // pointer only matters under contention; a lone requester always wins
        w_g0 = w_serve && req0_valid && (!req1_valid || !r_ptr);
        w_g1 = w_serve && req1_valid && (!req0_valid || r_ptr);
        w_any = w_g0 || w_g1;
        w_wr = w_g0 ? req0_write : req1_write;
        w_addr = w_g0 ? req0_addr : req1_addr;
        w_next = (r_state == INIT && r_cnt == {ADDR_WIDTH{1'b1}}) ? SERVE : r_state;
        req0_ready = w_g0;
        req1_ready = w_g1;
        mem_readEnable = w_any && !w_wr;
        mem_readAddress = (w_any && !w_wr) ? w_addr : '0;
        mem_writeEnable = w_clear || (w_any && w_wr);
        mem_writeAddress = (r_state == INIT) ? r_cnt : (w_any && w_wr) ? w_addr : '0;
        mem_writeData = (w_any && w_wr && !w_clear) ? (w_g0 ? req0_wdata : req1_wdata) : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= INIT_CLEAR ? INIT : SERVE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_ptr       <= 1'b0;
            r_init_done <= 1'b0;
            r_rvalid    <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
            r_init_done <= r_init_done || w_next == SERVE;
            r_rvalid    <= {w_g1, w_g0};
            if (w_g0) r_rdata0 <= req0_write ? '0 : mem_readData;
            if (w_g1) r_rdata1 <= req1_write ? '0 : mem_readData;
            // the loser of this grant gets priority next time
            if (w_any) r_ptr <= w_g0;
        end
    end

    // a response due while reset is asserted is dropped, not delivered late
    assign resp0_valid = r_rvalid[0] && reset;
    assign resp1_valid = r_rvalid[1] && reset;
    assign resp0_rdata = r_rdata0;
    assign resp1_rdata = r_rdata1;
    assign init_done   = r_init_done;
endmodule

// File: tb/tb_bsram_arbiter.sv
// tb_bsram_arbiter: directed and random checks of bsram_arbiter against a behavioural model
module tb_bsram_arbiter;
    logic        clock = 0, reset = 0;
    logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [3:0]  req0_addr = 0, req1_addr = 0;
    logic [31:0] req0_wdata = 0, req1_wdata = 0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        mem_readEnable, mem_writeEnable, init_done;
    logic [3:0]  mem_readAddress, mem_writeAddress;
    logic [31:0] mem_writeData, mem_readData;
    logic        report = 0;
    logic [31:0] sram [16];
    int          checks = 0, failures = 0;
    bit          m_serve, m_done, m_rv0, m_rv1;
    int          m_cnt, m_ptr;
    logic [31:0] m_rd0, m_rd1;
    logic [31:0] model_mem [16];
    bit          seen_r0, seen_r1, seen_rv0;
    logic [3:0]  seen_wa;
    int          first;

    bsram_arbiter #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(4), .INIT_CLEAR(1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress), .mem_writeEnable(mem_writeEnable),
        .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData), .mem_readData(mem_readData),
        .init_done(init_done), .report(report)
    );

    always #5 clock = ~clock;
    assign mem_readData = sram[mem_readAddress];
    always @(posedge clock) if (mem_writeEnable) sram[mem_writeAddress] <= mem_writeData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: compare outputs mid-cycle against the model, then advance the model at the edge
    task automatic cycle();
        int win;
        bit wr;
        logic [3:0] a;
        @(negedge clock);
        win = -1;
        if (m_serve && reset) begin
            if (req0_valid && req1_valid) win = m_ptr;
            else if (req0_valid) win = 0;
            else if (req1_valid) win = 1;
        end
        wr = (win == 0) ? req0_write : req1_write;
        a = (win == 0) ? req0_addr : req1_addr;
        seen_r0 = req0_ready; seen_r1 = req1_ready; seen_rv0 = resp0_valid; seen_wa = mem_writeAddress;
        chk("ready0", 32'(req0_ready), 32'(win == 0));
        chk("ready1", 32'(req1_ready), 32'(win == 1));
        chk("init_done", 32'(init_done), 32'(m_done));
        chk("resp0_valid", 32'(resp0_valid), 32'(m_rv0 && reset));
        chk("resp1_valid", 32'(resp1_valid), 32'(m_rv1 && reset));
        if (m_rv0 && reset) chk("resp0_rdata", resp0_rdata, m_rd0);
        if (m_rv1 && reset) chk("resp1_rdata", resp1_rdata, m_rd1);
        if (!reset) begin
            chk("rst_re", 32'(mem_readEnable), 0);
            chk("rst_we", 32'(mem_writeEnable), 0);
        end else if (!m_serve) begin
            chk("init_we", 32'(mem_writeEnable), 1);
            chk("init_wa", 32'(mem_writeAddress), m_cnt);
            chk("init_wd", mem_writeData, 0);
            chk("init_re", 32'(mem_readEnable), 0);
        end else if (win < 0) begin
            chk("idle_mem", {mem_readEnable, mem_writeEnable, 14'(0), mem_readAddress, mem_writeAddress, 8'(0)}, 0);
            chk("idle_wd", mem_writeData, 0);
        end else if (wr) begin
            chk("wr_we", 32'(mem_writeEnable), 1);
            chk("wr_re", 32'(mem_readEnable), 0);
            chk("wr_wa", 32'(mem_writeAddress), 32'(a));
            chk("wr_wd", mem_writeData, (win == 0) ? req0_wdata : req1_wdata);
        end else begin
            chk("rd_re", 32'(mem_readEnable), 1);
            chk("rd_we", 32'(mem_writeEnable), 0);
            chk("rd_ra", 32'(mem_readAddress), 32'(a));
        end
        @(posedge clock);
        if (!reset) begin
            m_serve = 0; m_done = 0; m_cnt = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0;
        end else if (!m_serve) begin
            model_mem[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == 16) begin m_serve = 1; m_done = 1; end
            m_rv0 = 0; m_rv1 = 0;
        end else begin
            m_rv0 = (win == 0); m_rv1 = (win == 1);
            if (win >= 0) begin
                if (win == 0) m_rd0 = wr ? 0 : model_mem[a];
                else          m_rd1 = wr ? 0 : model_mem[a];
                if (wr) model_mem[a] = (win == 0) ? req0_wdata : req1_wdata;
                m_ptr = 1 - win;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin sram[i] = $urandom; model_mem[i] = 'x; end
        m_serve = 0; m_done = 0; m_cnt = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0;
        repeat (2) cycle();
        // read request held across the whole zero-fill
        reset = 1; req1_valid = 1; req1_write = 0; req1_addr = 5;
        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            cycle();
            if (seen_r1) first = i;
        end
        chk("init_hold_first_grant", first, 16);
        chk("init_hold_resp", {31'(0), resp1_valid}, 1);
        chk("init_hold_rdata", resp1_rdata, 0);
        req1_valid = 0;
        // contention: strict alternation, one grant per cycle
        req0_valid = 1; req1_valid = 1; req0_write = 0; req1_write = 0; req0_addr = 1; req1_addr = 2;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("alt_grant", {30'(0), seen_r1, seen_r0}, (i % 2) ? 2 : 1);
            chk("alt_resp", {30'(0), resp1_valid, resp0_valid}, (i % 2) ? 2 : 1);
        end
        req1_valid = 0;
        // write then read back
        req0_write = 1; req0_addr = 3; req0_wdata = 32'hDEADBEEF;
        cycle();
        chk("wr_resp_valid", 32'(resp0_valid), 1);
        chk("wr_resp_rdata", resp0_rdata, 0);
        req0_write = 0;
        cycle();
        chk("rd_resp_valid", 32'(resp0_valid), 1);
        chk("rd_resp_rdata", resp0_rdata, 32'hDEADBEEF);
        req0_valid = 0;
        cycle();
        chk("resp_single_pulse", 32'(resp0_valid), 0);
        // lone req1 for three cycles, then contention must favour req0
        req1_valid = 1; req1_addr = 7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lone_req1", 32'(seen_r1), 1);
        end
        req0_valid = 1;
        cycle();
        chk("after_lone_grant", {30'(0), seen_r1, seen_r0}, 1);
        // reset right after a granted read
        req1_valid = 0; req0_addr = 3;
        cycle();
        reset = 0; req0_valid = 0;
        cycle();
        chk("reset_drops_resp", 32'(seen_rv0), 0);
        reset = 1; req0_valid = 1; req1_valid = 1; req1_addr = 4;
        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            cycle();
            if (i == 0) chk("reinit_addr0", 32'(seen_wa), 0);
            if (seen_r0 || seen_r1) first = i;
        end
        chk("reinit_first_grant", first, 16);
        chk("reinit_ptr0", {30'(0), seen_r1, seen_r0}, 1);
        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 60) != 0;
            req0_valid = 1'($urandom); req0_write = 1'($urandom); req0_addr = 4'($urandom); req0_wdata = $urandom;
            req1_valid = 1'($urandom); req1_write = 1'($urandom); req1_addr = 4'($urandom); req1_wdata = $urandom;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
